// File: rtl/fifo_mac_pkg.sv
// ---------------------------------------------------------------------------
// fifo_mac_pkg
//   Shared types and default widths for the fifo_mac block.
//   - mac_state_t : controller state encoding (IDLE, RUN, DRAIN, DONE)
//   - DEF_*       : default parameter values used by the interface, the
//                   pipeline and the top level
//   Optional build macro used elsewhere in the block: FIFO_MAC_SATURATE_EN.
// ---------------------------------------------------------------------------
package fifo_mac_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_PAIRS  = 8;
    localparam int DEF_ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage : fifo_mac_pkg

// File: rtl/fifo_mac_if.sv
// ---------------------------------------------------------------------------
// fifo_mac_if
//   Bundle of the two show-ahead operand FIFO read ports seen by fifo_mac.
//   Signals:
//     a_empty, b_empty : FIFO empty flags (head invalid while high)
//     a_data,  b_data  : FIFO heads, valid while the matching empty is low
//     a_rden,  b_rden  : pop strobes from the consumer
//   Modports:
//     master : the consumer (fifo_mac) - reads flags/data, drives rden
//     slave  : the FIFO side           - drives flags/data, reads rden
//
//   Handshake: "valid" is !x_empty, "ready" is x_rden. A head is consumed on
//   the rising clock edge that ends a cycle in which x_rden is high; x_rden is
//   only ever raised while the matching x_empty is low, and a_rden/b_rden are
//   always raised together so the two FIFOs stay in lock-step.
// ---------------------------------------------------------------------------
interface fifo_mac_if #(
    parameter int DATA_WIDTH = fifo_mac_pkg::DEF_DATA_WIDTH
);

    logic                  a_empty;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  a_rden;
    logic                  b_rden;

    modport master (
        input  a_empty,
        input  b_empty,
        input  a_data,
        input  b_data,
        output a_rden,
        output b_rden
    );

    modport slave (
        output a_empty,
        output b_empty,
        output a_data,
        output b_data,
        input  a_rden,
        input  b_rden
    );

endinterface : fifo_mac_if

// File: rtl/fifo_mac_pipe.sv
// ---------------------------------------------------------------------------
// mac_pipe
//   Two-stage multiply/accumulate datapath for fifo_mac.
//     stage 1 : operand registers a1/b1, valid v1 (loaded when valid=1)
//     stage 2 : product register p2 (2*DATA_WIDTH, unsigned), valid v2
//     acc     : accumulator, adds the zero-extended p2 when v2=1
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     valid      : a/b hold a popped operand pair this cycle
//     a, b       : operands (unsigned)
//     clr        : clear accumulator and overflow (start of a run)
//     acc        : accumulator value
//     overflow   : sticky, accumulator exceeded 2^ACC_WIDTH-1 this run
//     pipe_busy  : a pair is still in flight that will not have reached the
//                  accumulator by the next clock edge
//   Build option FIFO_MAC_SATURATE_EN: clamp the accumulator at all-ones on
//   overflow instead of wrapping.
// ---------------------------------------------------------------------------
module mac_pipe
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  clr,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  overflow,
    output logic                  pipe_busy
);

    localparam int PW = 2 * DATA_WIDTH;

    logic                  v1;
    logic                  v2;
    logic [DATA_WIDTH-1:0] a1;
    logic [DATA_WIDTH-1:0] b1;
    logic [PW-1:0]         p2;
    logic [ACC_WIDTH:0]    sum;
    logic                  carry;

    // One spare bit on top of the accumulator catches the carry-out.
    assign sum   = {1'b0, acc} + {{(ACC_WIDTH + 1 - PW){1'b0}}, p2};
    assign carry = sum[ACC_WIDTH];

    // Whatever sits in stage 2 lands in acc on the coming edge, so only
    // stage 1 still counts as outstanding work.
    assign pipe_busy = v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            v2 <= 1'b0;
            p2 <= '0;
        end else begin
            v1 <= valid;
            if (valid) begin
                a1 <= a;
                b1 <= b;
            end
            v2 <= v1;
            if (v1) begin
                p2 <= PW'(a1) * PW'(b1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (v2) begin
`ifdef FIFO_MAC_SATURATE_EN
            // Once clamped, acc is all-ones: any further non-zero product
            // carries out again and a zero product leaves it unchanged, so
            // the clamp holds for the rest of the run without extra state.
            if (carry) begin
                acc      <= '1;
                overflow <= 1'b1;
            end else begin
                acc <= sum[ACC_WIDTH-1:0];
            end
`else
            acc <= sum[ACC_WIDTH-1:0];
            if (carry) begin
                overflow <= 1'b1;
            end
`endif
        end
    end

endmodule : mac_pipe

// File: rtl/fifo_mac.sv
// ---------------------------------------------------------------------------
// fifo_mac
//   Consumes NUM_PAIRS operand pairs from two show-ahead FIFOs after a start
//   pulse, accumulates the unsigned dot product through mac_pipe and reports
//   it with a one-cycle done pulse.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : pulse, begins a run when IDLE (ignored otherwise)
//     fif       : operand FIFO read ports (fifo_mac_if.master)
//     busy      : high in RUN, DRAIN and DONE
//     done      : one-cycle pulse, result final
//     result    : accumulator, held until the next start
//     overflow  : sticky overflow flag for the current/last run
//     dbg_state : current controller state
//   Build option FIFO_MAC_SATURATE_EN (in mac_pipe): saturating accumulator.
// ---------------------------------------------------------------------------
module fifo_mac
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PAIRS  = DEF_NUM_PAIRS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fifo_mac_if.master           fif,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 overflow,
    output mac_state_t           dbg_state
);

    localparam int CW = $clog2(NUM_PAIRS + 1);

    mac_state_t    state;
    mac_state_t    state_nxt;
    logic [CW-1:0] count;
    logic          pop;
    logic          clr;
    logic          pipe_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                end
            end
            RUN: begin
                pop = !fif.a_empty && !fif.b_empty && (count < CW'(NUM_PAIRS));
                if (pop && (count == CW'(NUM_PAIRS - 1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the pipe will be empty after this edge, so
                // done lands three cycles after the last pop.
                if (!pipe_busy) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (pop) begin
            count <= count + 1'b1;
        end
    end

    // Both FIFOs are always popped together.
    assign fif.a_rden = pop;
    assign fif.b_rden = pop;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid     (pop),
        .a         (fif.a_data),
        .b         (fif.b_data),
        .clr       (clr),
        .acc       (result),
        .overflow  (overflow),
        .pipe_busy (pipe_busy)
    );

endmodule : fifo_mac

// File: tb/tb_fifo_mac.sv
// ---------------------------------------------------------------------------
// tb_fifo_mac
//   Directed bench for fifo_mac built with ACC_WIDTH=16 so the overflow and
//   saturation boundaries are reachable with 8-bit operands. Queue-based
//   show-ahead FIFO models feed the DUT; expected results are hand-computed
//   constants held in a vector table and pushed to a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_fifo_mac;
  import fifo_mac_pkg::*;

  localparam int DW = 8;
  localparam int NP = 8;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic          busy;
  logic          done;
  logic [AW-1:0] result;
  logic          overflow;
  mac_state_t    dbg_state;

  fifo_mac_if #(.DATA_WIDTH(DW)) fif();

  fifo_mac #(
    .DATA_WIDTH (DW),
    .NUM_PAIRS  (NP),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fif       (fif),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- FIFO models / scoreboard ----------------
  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];
  logic [DW-1:0] b_src[$];
  logic [AW-1:0] exp_q[$];
  logic          exp_ovf_q[$];
  bit            trickle;

  int cyc;
  int pop_cnt;
  int done_cnt;
  int last_pop_cyc;
  int done_cyc;
  int n_cmp;
  int n_fail;

  typedef struct {
    logic [DW-1:0] a[NP];
    logic [DW-1:0] b[NP];
    bit            trickle;
    logic [AW-1:0] exp_res;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_heads();
    fif.a_empty = (a_q.size() == 0);
    fif.b_empty = (b_q.size() == 0);
    fif.a_data  = (a_q.size() > 0) ? a_q[0] : '0;
    fif.b_data  = (b_q.size() > 0) ? b_q[0] : '0;
  endtask

  // One clock: observe at the falling edge, update the FIFO models just
  // after the rising edge.
  task automatic tick();
    logic popped;
    logic [AW-1:0] e_res;
    logic          e_ovf;
    @(negedge clk);
    popped = fif.a_rden;
    n_cmp++;
    if ((fif.a_rden !== fif.b_rden) || (fif.a_rden && (fif.a_empty || fif.b_empty))) begin
      n_fail++;
      $display("FAIL rden_rule: a_rden=%b b_rden=%b a_empty=%b b_empty=%b, required equal and only when both non-empty (t=%0t)",
               fif.a_rden, fif.b_rden, fif.a_empty, fif.b_empty, $time);
    end
    if (popped === 1'b1) begin
      pop_cnt++;
      last_pop_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e_res = exp_q.pop_front();
        e_ovf = exp_ovf_q.pop_front();
        check("done_result", 32'(result), 32'(e_res));
        check("done_overflow", 32'(overflow), 32'(e_ovf));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (popped === 1'b1) begin
      if (a_q.size() > 0) void'(a_q.pop_front());
      if (b_q.size() > 0) void'(b_q.pop_front());
    end
    if (trickle && (b_src.size() > 0) && (cyc % 3 == 0)) begin
      b_q.push_back(b_src.pop_front());
    end
    drive_heads();
  endtask

  // Load a vector plus one extra entry per FIFO that must never be popped.
  task automatic load_vec(input int idx);
    a_q.delete();
    b_q.delete();
    b_src.delete();
    trickle = vecs[idx].trickle;
    for (int i = 0; i < NP; i++) begin
      a_q.push_back(vecs[idx].a[i]);
      if (trickle) b_src.push_back(vecs[idx].b[i]);
      else         b_q.push_back(vecs[idx].b[i]);
    end
    a_q.push_back(8'h5a);
    if (trickle) b_src.push_back(8'h5a);
    else         b_q.push_back(8'h5a);
    drive_heads();
  endtask

  task automatic pulse_start();
    pop_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    if (done_cnt == d0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    int d0;
    load_vec(idx);
    exp_q.push_back(vecs[idx].exp_res);
    exp_ovf_q.push_back(vecs[idx].exp_ovf);
    d0 = done_cnt;
    pulse_start();
    wait_done($sformatf("vec%0d", idx), d0);
    check($sformatf("vec%0d_pops", idx), 32'(pop_cnt), 32'(NP));
    check($sformatf("vec%0d_latency", idx), 32'(done_cyc - last_pop_cyc), 32'd3);
    check($sformatf("vec%0d_leftover", idx), 32'(a_q.size() + b_q.size() + b_src.size()), 32'd2);
    tick();
    check($sformatf("vec%0d_idle_after", idx), 32'(busy), 32'd0);
    trickle = 1'b0;
  endtask

  initial begin
    int d0;
    n_cmp = 0; n_fail = 0; cyc = 0; pop_cnt = 0; done_cnt = 0;
    last_pop_cyc = 0; done_cyc = 0; trickle = 1'b0;

    // ---------------- vector table (hand-computed) ----------------
    // 1^2+..+8^2 = 204
    vecs[0].a = '{1, 2, 3, 4, 5, 6, 7, 8};  vecs[0].b = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecs[0].trickle = 1'b0; vecs[0].exp_res = 16'd204; vecs[0].exp_ovf = 1'b0;
    // back-to-back after 204: accumulator must restart, 8 not 212
    vecs[1].a = '{1, 1, 1, 1, 1, 1, 1, 1};  vecs[1].b = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[1].trickle = 1'b0; vecs[1].exp_res = 16'd8; vecs[1].exp_ovf = 1'b0;
    // B arrives one entry every 3 cycles
    vecs[2].a = '{1, 2, 3, 4, 5, 6, 7, 8};  vecs[2].b = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecs[2].trickle = 1'b1; vecs[2].exp_res = 16'd204; vecs[2].exp_ovf = 1'b0;
    // 8+14+18+20+20+18+14+8 = 120
    vecs[3].a = '{1, 2, 3, 4, 5, 6, 7, 8};  vecs[3].b = '{8, 7, 6, 5, 4, 3, 2, 1};
    vecs[3].trickle = 1'b0; vecs[3].exp_res = 16'd120; vecs[3].exp_ovf = 1'b0;
    // 8*65025 = 520200 -> mod 65536 = 61448, or clamp at 65535
    vecs[4].a = '{255, 255, 255, 255, 255, 255, 255, 255};
    vecs[4].b = '{255, 255, 255, 255, 255, 255, 255, 255};
    vecs[4].trickle = 1'b0; vecs[4].exp_ovf = 1'b1;
`ifdef FIFO_MAC_SATURATE_EN
    vecs[4].exp_res = 16'd65535;
`else
    vecs[4].exp_res = 16'd61448;
`endif
    // 65025 + 510 = 65535: exactly full, no overflow (also clears the flag)
    vecs[5].a = '{255, 2, 0, 0, 0, 0, 0, 0}; vecs[5].b = '{255, 255, 0, 0, 0, 0, 0, 0};
    vecs[5].trickle = 1'b0; vecs[5].exp_res = 16'd65535; vecs[5].exp_ovf = 1'b0;
    // 65025 + 510 + 1 = 65536: one past full
    vecs[6].a = '{255, 2, 1, 0, 0, 0, 0, 0}; vecs[6].b = '{255, 255, 1, 0, 0, 0, 0, 0};
    vecs[6].trickle = 1'b0; vecs[6].exp_ovf = 1'b1;
`ifdef FIFO_MAC_SATURATE_EN
    vecs[6].exp_res = 16'd65535;
`else
    vecs[6].exp_res = 16'd0;
`endif
    // used after the mid-run reset: 8*2*3 = 48
    vecs[7].a = '{2, 2, 2, 2, 2, 2, 2, 2};  vecs[7].b = '{3, 3, 3, 3, 3, 3, 3, 3};
    vecs[7].trickle = 1'b0; vecs[7].exp_res = 16'd48; vecs[7].exp_ovf = 1'b0;

    // ---------------- reset ----------------
    rst = 1'b1;
    start = 1'b0;
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rden", 32'({fif.a_rden, fif.b_rden}), 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- table-driven runs ----------------
    for (int v = 0; v < 7; v++) run_vec(v);

    // ---------------- reset in the middle of a run ----------------
    load_vec(0);
    pulse_start();
    for (int i = 0; i < 20 && pop_cnt < 3; i++) tick();
    check("midrst_pops_before", 32'(pop_cnt), 32'd3);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rden", 32'({fif.a_rden, fif.b_rden}), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    a_q.delete();
    b_q.delete();
    drive_heads();
    tick();
    rst = 1'b0;
    tick();
    run_vec(7);

    // ---------------- start during RUN and in the DONE cycle ----------------
    load_vec(0);
    exp_q.push_back(16'd204);
    exp_ovf_q.push_back(1'b0);
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 20 && pop_cnt < 2; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
    check("ign_reached_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("ign_done_count", 32'(done_cnt - d0), 32'd1);
    check("ign_pops", 32'(pop_cnt), 32'(NP));
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_result_held", 32'(result), 32'd204);
    check("ign_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fifo_mac
